uart_if_host_bridge: RTL and testbench

UART_IF_HOST_BRIDGE -- requirements
Module: uart_if_host_bridge

---
 rtl/uart_if_host_bridge_if.sv | 35 +++
 rtl/uart_if_host_bridge.sv | 172 +++++++++++++++++
 tb/tb_uart_if_host_bridge.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_if_host_bridge_if.sv
// Host-side FIFO handshake and UART register bus of uart_if_host_bridge.
// master = host plus UART register file; slave = the bridge.
interface uart_if_host_bridge_if #(
    parameter int unsigned FIFO_AW = 2
);
    logic [7:0]       txByte;
    logic             txValid;
    logic             txReady;
    logic [7:0]       rxByte;
    logic [1:0]       rxErr;
    logic             rxValid;
    logic             rxReady;
    logic             flush;
    logic [7:0]       ifDataIn;
    logic             ifNWe;
    logic [7:0]       ifDataOut;
    logic             ifNCsData;
    logic [7:0]       ifStatus;
    logic             ifNCsStatus;
    logic [FIFO_AW:0] txLevel;
    logic [FIFO_AW:0] rxLevel;
    logic [7:0]       errCount;

    modport master (
        output txByte, txValid, rxReady, flush, ifDataOut, ifStatus,
        input  txReady, rxByte, rxErr, rxValid, ifDataIn, ifNWe, ifNCsData,
               ifNCsStatus, txLevel, rxLevel, errCount
    );

    modport slave (
        input  txByte, txValid, rxReady, flush, ifDataOut, ifStatus,
        output txReady, rxByte, rxErr, rxValid, ifDataIn, ifNWe, ifNCsData,
               ifNCsStatus, txLevel, rxLevel, errCount
    );
endinterface

// File: rtl/uart_if_host_bridge.sv
// Bridges host TX/RX byte FIFOs to a strobed UART register interface.
// Optional RX_ERR_DROP_EN: drop framing-error bytes and count them in errCount.
module uart_if_host_bridge #(
    parameter int unsigned FIFO_AW = 2
) (
    input  logic                 clk,
    input  logic                 nReset,
    uart_if_host_bridge_if.slave bus
);
    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned LW    = FIFO_AW + 1;
    localparam int unsigned RXW   = 10;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] WR   = 2'd2;
    localparam logic [1:0] HOLD = 2'd3;

    logic [1:0]         state;
    logic [1:0]         stateNext;
    logic               holdCnt;

    logic [7:0]         txMem [DEPTH];
    logic [FIFO_AW-1:0] txWrPtr;
    logic [FIFO_AW-1:0] txRdPtr;
    logic [LW-1:0]      txLevelNext;
    logic               txPush;
    logic               txPop;
    logic               txEmpty;

    logic [RXW-1:0]     rxMem [DEPTH];
    logic [FIFO_AW-1:0] rxWrPtr;
    logic [FIFO_AW-1:0] rxRdPtr;
    logic [FIFO_AW-1:0] rxRdPtrNext;
    logic [LW-1:0]      rxLevelNext;
    logic [RXW-1:0]     rxData;
    logic [RXW-1:0]     rxHeadNext;
    logic               rxCapture;
    logic               rxDrop;
    logic               rxPush;
    logic               rxPop;
    logic               rxFull;

    logic               rxAvail;
    logic               txFree;
    logic               unusedStatus;

    // Status decode: {txRun, txPending, rxRun, rxStartBit, isTx, ovr, frm, bufferFull}
    assign rxAvail      = bus.ifStatus[0] & ~bus.ifStatus[6] & ~bus.ifStatus[7];
    assign txFree       = ~bus.ifStatus[0] & ~bus.ifStatus[6] & ~bus.ifStatus[7]
                        & ~bus.ifStatus[5] & ~bus.ifStatus[4];
    assign unusedStatus = bus.ifStatus[3];
    assign bus.ifNCsStatus = 1'b0;

    assign txEmpty   = (bus.txLevel == '0);
    assign rxFull    = (bus.rxLevel == LW'(DEPTH));
    assign txPush    = bus.txValid & bus.txReady;
    assign txPop     = (state == IDLE) && (stateNext == WR);
    assign rxData    = {bus.ifStatus[2:1], bus.ifDataOut};
    assign rxCapture = (state == RD) && !bus.flush;
`ifdef RX_ERR_DROP_EN
    assign rxDrop    = bus.ifStatus[1];
`else
    assign rxDrop    = 1'b0;
`endif
    assign rxPush    = rxCapture & ~rxDrop;
    assign rxPop     = bus.rxValid & bus.rxReady;

    // Next state; RX wins over TX, and no new strobe starts during a flush
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (!bus.flush) begin
                    if (rxAvail && !rxFull)      stateNext = RD;
                    else if (!txEmpty && txFree) stateNext = WR;
                end
            end
            RD, WR:  stateNext = HOLD;
            HOLD:    if (holdCnt) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // FIFO level bookkeeping and RX head lookahead (bypass when the pushed byte becomes head)
    always_comb begin
        txLevelNext = bus.txLevel;
        if (txPush && !txPop)      txLevelNext = bus.txLevel + LW'(1);
        else if (!txPush && txPop) txLevelNext = bus.txLevel - LW'(1);

        rxLevelNext = bus.rxLevel;
        if (rxPush && !rxPop)      rxLevelNext = bus.rxLevel + LW'(1);
        else if (!rxPush && rxPop) rxLevelNext = bus.rxLevel - LW'(1);

        rxRdPtrNext = rxPop ? rxRdPtr + FIFO_AW'(1) : rxRdPtr;
        rxHeadNext  = (rxPush && (rxRdPtrNext == rxWrPtr)) ? rxData : rxMem[rxRdPtrNext];
    end

    // State register with registered strobes
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state         <= IDLE;
            holdCnt       <= 1'b0;
            bus.ifNWe     <= 1'b1;
            bus.ifNCsData <= 1'b1;
            bus.ifDataIn  <= 8'h00;
        end else begin
            state         <= stateNext;
            holdCnt       <= (state == HOLD) ? ~holdCnt : 1'b0;
            bus.ifNWe     <= (stateNext != WR);
            bus.ifNCsData <= (stateNext != RD);
            if (txPop) bus.ifDataIn <= txMem[txRdPtr];
        end
    end

    always_ff @(posedge clk) begin
        if (txPush && !bus.flush) txMem[txWrPtr] <= bus.txByte;
        if (rxPush)               rxMem[rxWrPtr] <= rxData;
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            txWrPtr     <= '0;
            txRdPtr     <= '0;
            bus.txLevel <= '0;
            bus.txReady <= 1'b1;
        end else if (bus.flush) begin
            txWrPtr     <= '0;
            txRdPtr     <= '0;
            bus.txLevel <= '0;
            bus.txReady <= 1'b1;
        end else begin
            if (txPush) txWrPtr <= txWrPtr + FIFO_AW'(1);
            if (txPop)  txRdPtr <= txRdPtr + FIFO_AW'(1);
            bus.txLevel <= txLevelNext;
            bus.txReady <= (txLevelNext != LW'(DEPTH));
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            rxWrPtr                 <= '0;
            rxRdPtr                 <= '0;
            bus.rxLevel             <= '0;
            bus.rxValid             <= 1'b0;
            {bus.rxErr, bus.rxByte} <= '0;
        end else if (bus.flush) begin
            rxWrPtr                 <= '0;
            rxRdPtr                 <= '0;
            bus.rxLevel             <= '0;
            bus.rxValid             <= 1'b0;
            {bus.rxErr, bus.rxByte} <= '0;
        end else begin
            if (rxPush) rxWrPtr <= rxWrPtr + FIFO_AW'(1);
            rxRdPtr                 <= rxRdPtrNext;
            bus.rxLevel             <= rxLevelNext;
            bus.rxValid             <= (rxLevelNext != '0);
            {bus.rxErr, bus.rxByte} <= rxHeadNext;
        end
    end

`ifdef RX_ERR_DROP_EN
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset)
            bus.errCount <= 8'h00;
        else if (rxCapture && rxDrop && (bus.errCount != 8'hFF))
            bus.errCount <= bus.errCount + 8'd1;
    end
`else
    assign bus.errCount = 8'h00;
`endif
endmodule

// File: tb/tb_uart_if_host_bridge.sv
// Scoreboard bench for uart_if_host_bridge: stimulus queues expected strobes/pops,
// a negedge monitor compares every observed UART strobe and host RX pop.
module tb_uart_if_host_bridge;
    localparam logic [1:0] EV_RD  = 2'd1;
    localparam logic [1:0] EV_WR  = 2'd2;
    localparam logic [1:0] EV_POP = 2'd3;

    logic clk;
    logic nReset;
    int   nCmp;
    int   nBad;
    logic [11:0] expQ [$];

    uart_if_host_bridge_if #(.FIFO_AW(2)) bus ();

    uart_if_host_bridge #(.FIFO_AW(2)) dut (
        .clk    (clk),
        .nReset (nReset),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic scoreEvent(input logic [11:0] act);
        nCmp++;
        if (expQ.size() == 0) begin
            nBad++;
            $display("FAIL unexpected_event: got kind %0d data 0x%0h required none", act[11:10], act[9:0]);
        end else begin
            logic [11:0] exp;
            exp = expQ.pop_front();
            if (act !== exp) begin
                nBad++;
                $display("FAIL event_order: got kind %0d data 0x%0h required kind %0d data 0x%0h",
                         act[11:10], act[9:0], exp[11:10], exp[9:0]);
            end
        end
    endtask

    // Monitor: strobes are registered, so sampling at negedge is stable
    always @(negedge clk) begin
        if (nReset) begin
            nCmp++;
            if (!bus.ifNWe && !bus.ifNCsData) begin
                nBad++;
                $display("FAIL strobe_overlap: got ifNWe=0 ifNCsData=0 required at most one low");
            end
            if (!bus.ifNCsData)            scoreEvent({EV_RD, 10'd0});
            if (!bus.ifNWe)                scoreEvent({EV_WR, 2'b00, bus.ifDataIn});
            if (bus.rxValid && bus.rxReady) scoreEvent({EV_POP, bus.rxErr, bus.rxByte});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for the read strobe, let the capture edge pass, then empty the UART buffer
    task automatic waitRdClear(input string name);
        int n;
        n = 0;
        while (bus.ifNCsData !== 1'b0 && n < 30) begin
            tick();
            n++;
        end
        nCmp++;
        if (bus.ifNCsData !== 1'b0) begin
            nBad++;
            $display("FAIL %s: got no read strobe in 30 cycles required ifNCsData=0", name);
        end
        tick();
        bus.ifStatus = 8'h00;
    endtask

    task automatic rxIn(input string name, input logic [7:0] data, input logic [7:0] status);
        bus.ifDataOut = data;
        bus.ifStatus  = status;
        waitRdClear(name);
    endtask

    task automatic popOne();
        bus.rxReady = 1'b1;
        tick();
        bus.rxReady = 1'b0;
    endtask

    task automatic pushTx(input logic [7:0] b);
        bus.txByte  = b;
        bus.txValid = 1'b1;
        tick();
        bus.txValid = 1'b0;
    endtask

    initial begin
        nCmp = 0;
        nBad = 0;
        nReset        = 1'b0;
        bus.txByte    = 8'h00;
        bus.txValid   = 1'b0;
        bus.rxReady   = 1'b0;
        bus.flush     = 1'b0;
        bus.ifDataOut = 8'h00;
        bus.ifStatus  = 8'h00;
        repeat (3) tick();
        nReset = 1'b1;
        tick();

        chk("rst_txReady",     32'(bus.txReady),     32'd1);
        chk("rst_rxValid",     32'(bus.rxValid),     32'd0);
        chk("rst_rxByte",      32'(bus.rxByte),      32'h00);
        chk("rst_rxErr",       32'(bus.rxErr),       32'd0);
        chk("rst_ifNWe",       32'(bus.ifNWe),       32'd1);
        chk("rst_ifNCsData",   32'(bus.ifNCsData),   32'd1);
        chk("rst_ifDataIn",    32'(bus.ifDataIn),    32'h00);
        chk("rst_errCount",    32'(bus.errCount),    32'd0);
        chk("rst_txLevel",     32'(bus.txLevel),     32'd0);
        chk("rst_rxLevel",     32'(bus.rxLevel),     32'd0);
        chk("ifNCsStatus",     32'(bus.ifNCsStatus), 32'd0);

        // Single TX byte, idle status
        expQ.push_back({EV_WR, 2'b00, 8'h3B});
        pushTx(8'h3B);
        chk("tx_level_after_push", 32'(bus.txLevel), 32'd1);
        tick();
        chk("tx_level_after_wr", 32'(bus.txLevel), 32'd0);
        repeat (4) tick();

        // Single clean RX byte
        expQ.push_back({EV_RD, 10'd0});
        rxIn("rx_a5", 8'hA5, 8'h01);
        chk("rx_valid_a5", 32'(bus.rxValid), 32'd1);
        chk("rx_byte_a5",  32'(bus.rxByte),  32'hA5);
        chk("rx_err_a5",   32'(bus.rxErr),   32'd0);
        repeat (3) tick();
        expQ.push_back({EV_POP, 2'b00, 8'hA5});
        popOne();
        repeat (2) tick();

        // RX and TX pending together: read goes first
        expQ.push_back({EV_RD, 10'd0});
        expQ.push_back({EV_WR, 2'b00, 8'h22});
        bus.ifDataOut = 8'h77;
        bus.ifStatus  = 8'h01;
        pushTx(8'h22);
        waitRdClear("prio_rd");
        repeat (6) tick();
        expQ.push_back({EV_POP, 2'b00, 8'h77});
        popOne();
        repeat (2) tick();

        // rxRun blocks writes
        bus.ifStatus = 8'h20;
        pushTx(8'h11);
        repeat (10) tick();
        chk("tx_held_rxrun", 32'(bus.txLevel), 32'd1);
        expQ.push_back({EV_WR, 2'b00, 8'h11});
        bus.ifStatus = 8'h00;
        repeat (5) tick();
        chk("tx_drained_rxrun", 32'(bus.txLevel), 32'd0);

        // RX FIFO full: backpressure, then exactly one read per freed slot
        for (int i = 0; i < 4; i++) begin
            expQ.push_back({EV_RD, 10'd0});
            rxIn("rx_fill", 8'(8'h10 + i), 8'h01);
            repeat (3) tick();
        end
        chk("rx_level_full", 32'(bus.rxLevel), 32'd4);
        bus.ifDataOut = 8'h14;
        bus.ifStatus  = 8'h01;
        repeat (10) tick();
        chk("rx_level_held", 32'(bus.rxLevel), 32'd4);
        expQ.push_back({EV_POP, 2'b00, 8'h10});
        expQ.push_back({EV_RD, 10'd0});
        popOne();
        waitRdClear("rx_refill");
        repeat (4) tick();
        chk("rx_level_refull", 32'(bus.rxLevel), 32'd4);
        for (int i = 0; i < 4; i++) expQ.push_back({EV_POP, 2'b00, 8'(8'h11 + i)});
        bus.rxReady = 1'b1;
        repeat (4) tick();
        bus.rxReady = 1'b0;
        chk("rx_level_drained", 32'(bus.rxLevel), 32'd0);
        chk("rx_valid_drained", 32'(bus.rxValid), 32'd0);

        // TX FIFO full and flush
        bus.ifStatus = 8'h80;
        bus.txValid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.txByte = 8'(8'hC0 + i);
            tick();
        end
        bus.txValid = 1'b0;
        chk("tx_level_full", 32'(bus.txLevel), 32'd4);
        chk("tx_ready_full", 32'(bus.txReady), 32'd0);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("tx_level_flush", 32'(bus.txLevel), 32'd0);
        chk("tx_ready_flush", 32'(bus.txReady), 32'd1);
        bus.ifStatus = 8'h00;
        repeat (4) tick();
        expQ.push_back({EV_RD, 10'd0});
        rxIn("rx_flush", 8'hEE, 8'h01);
        chk("rx_valid_preflush", 32'(bus.rxValid), 32'd1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("rx_valid_flush", 32'(bus.rxValid), 32'd0);
        chk("rx_level_flush", 32'(bus.rxLevel), 32'd0);
        repeat (8) tick();

        // Framing error byte
        expQ.push_back({EV_RD, 10'd0});
        rxIn("rx_frm", 8'h55, 8'h03);
        repeat (3) tick();
`ifdef RX_ERR_DROP_EN
        chk("frm_dropped",  32'(bus.rxValid),  32'd0);
        chk("frm_errCount", 32'(bus.errCount), 32'd1);
`else
        chk("frm_valid",    32'(bus.rxValid),  32'd1);
        chk("frm_rxErr",    32'(bus.rxErr),    32'd1);
        chk("frm_rxByte",   32'(bus.rxByte),   32'h55);
        chk("frm_errCount", 32'(bus.errCount), 32'd0);
        expQ.push_back({EV_POP, 2'b01, 8'h55});
        popOne();
`endif
        repeat (10) tick();
        chk("scoreboard_empty", 32'(expQ.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule
